// File: rtl/alu_pkg.sv
// ALU issue controller shared definitions: ALU op codes, MIPS funct codes,
// exception codes and FSM state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_MULT = 4'd8;
    localparam logic [3:0] ALU_DIV  = 4'd9;

    localparam logic [5:0] OP_RTYPE = 6'h00;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_MFHI = 6'h10;
    localparam logic [5:0] F_MFLO = 6'h12;
    localparam logic [5:0] F_MULT = 6'h18;
    localparam logic [5:0] F_DIV  = 6'h1A;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_OVF     = 2'd1;
    localparam logic [1:0] EXC_ILLEGAL = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT = 2'd3;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_WB    = 2'd3;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of decode request, ALU en/done bus and writeback/exception strobes.
// master = issue controller, slave = decode + ALU + regfile side.
interface alu_issue_ctrl_if;

    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_opcode;
    logic [5:0]  req_funct;
    logic [4:0]  req_shamt;
    logic [31:0] req_rs_data;
    logic [31:0] req_rt_data;
    logic [4:0]  req_rd;

    logic        alu_en;
    logic [3:0]  alu_control;
    logic [31:0] alu_srcA;
    logic [31:0] alu_srcB;
    logic [31:0] alu_result;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        alu_overflow;
    logic        alu_done;

    logic        wb_valid;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exc_valid;
    logic [1:0]  exc_code;

    modport master (
        input  req_valid, req_opcode, req_funct, req_shamt,
        input  req_rs_data, req_rt_data, req_rd,
        output req_ready,
        output alu_en, alu_control, alu_srcA, alu_srcB,
        input  alu_result, alu_hi, alu_lo, alu_overflow, alu_done,
        output wb_valid, wb_addr, wb_data, exc_valid, exc_code
    );

    modport slave (
        output req_valid, req_opcode, req_funct, req_shamt,
        output req_rs_data, req_rt_data, req_rd,
        input  req_ready,
        input  alu_en, alu_control, alu_srcA, alu_srcB,
        output alu_result, alu_hi, alu_lo, alu_overflow, alu_done,
        input  wb_valid, wb_addr, wb_data, exc_valid, exc_code
    );

endinterface

// File: rtl/alu_funct_decode.sv
// Combinational R-type decoder: opcode/funct -> ALU op and control flags.
// Ports: opcode, funct in; alu_control, uses_shamt, is_mfhi, is_mflo,
// writes_rd, ovf_trap, illegal out.
module alu_funct_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [3:0] alu_control,
    output logic       uses_shamt,
    output logic       is_mfhi,
    output logic       is_mflo,
    output logic       writes_rd,
    output logic       ovf_trap,
    output logic       illegal
);

    logic rt;

    assign rt = (opcode == OP_RTYPE);

    always_comb begin
        alu_control = ALU_ADD;
        uses_shamt  = 1'b0;
        is_mfhi     = 1'b0;
        is_mflo     = 1'b0;
        writes_rd   = 1'b1;
        ovf_trap    = 1'b0;
        illegal     = 1'b0;
        unique case (1'b1)
            (rt && funct == F_ADD): begin
                alu_control = ALU_ADD;
                ovf_trap    = 1'b1;
            end
            (rt && funct == F_ADDU): alu_control = ALU_ADD;
            (rt && funct == F_SUB): begin
                alu_control = ALU_SUB;
                ovf_trap    = 1'b1;
            end
            (rt && funct == F_SUBU): alu_control = ALU_SUB;
            (rt && funct == F_AND):  alu_control = ALU_AND;
            (rt && funct == F_OR):   alu_control = ALU_OR;
            (rt && funct == F_NOR):  alu_control = ALU_NOR;
            (rt && funct == F_SLT):  alu_control = ALU_SLT;
            (rt && funct == F_SLL): begin
                alu_control = ALU_SLL;
                uses_shamt  = 1'b1;
            end
            (rt && funct == F_SRL): begin
                alu_control = ALU_SRL;
                uses_shamt  = 1'b1;
            end
            (rt && funct == F_MULT): begin
                alu_control = ALU_MULT;
                writes_rd   = 1'b0;
            end
            // Divide-by-zero arrives on alu_overflow and traps.
            (rt && funct == F_DIV): begin
                alu_control = ALU_DIV;
                writes_rd   = 1'b0;
                ovf_trap    = 1'b1;
            end
            (rt && funct == F_MFHI): is_mfhi = 1'b1;
            (rt && funct == F_MFLO): is_mflo = 1'b1;
            default: begin
                illegal   = 1'b1;
                writes_rd = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: takes one R-type op per handshake, drives the ALU, and
// emits a regfile writeback or exception. Ports: clk, rst_n, bus (master).
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic clk,
    input  logic rst_n,
    alu_issue_ctrl_if.master bus
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [3:0]    ctrl_q;
    logic [31:0]   srca_q;
    logic [31:0]   srcb_q;
    logic [31:0]   res_q;
    logic [4:0]    rd_q;
    logic          wr_q;
    logic          trap_q;
    logic          mfhi_q;
    logic          mflo_q;
    logic [1:0]    exc_q;

    logic [3:0] d_ctrl;
    logic       d_shamt;
    logic       d_mfhi;
    logic       d_mflo;
    logic       d_wr;
    logic       d_trap;
    logic       d_ill;
    logic       hs;

    alu_funct_decode u_dec (
        .opcode      (bus.req_opcode),
        .funct       (bus.req_funct),
        .alu_control (d_ctrl),
        .uses_shamt  (d_shamt),
        .is_mfhi     (d_mfhi),
        .is_mflo     (d_mflo),
        .writes_rd   (d_wr),
        .ovf_trap    (d_trap),
        .illegal     (d_ill)
    );

    assign hs            = bus.req_valid && bus.req_ready;
    assign bus.req_ready = (state == S_IDLE);
    assign bus.alu_en    = (state == S_ISSUE);
    assign bus.alu_control = ctrl_q;
    assign bus.alu_srcA    = srca_q;
    assign bus.alu_srcB    = srcb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ctrl_q <= '0;
            srca_q <= '0;
            srcb_q <= '0;
            res_q  <= '0;
            rd_q   <= '0;
            wr_q   <= 1'b0;
            trap_q <= 1'b0;
            mfhi_q <= 1'b0;
            mflo_q <= 1'b0;
            exc_q  <= EXC_NONE;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (hs) begin
                        rd_q   <= bus.req_rd;
                        wr_q   <= d_wr;
                        trap_q <= d_trap;
                        mfhi_q <= d_mfhi;
                        mflo_q <= d_mflo;
                        res_q  <= '0;
                        exc_q  <= d_ill ? EXC_ILLEGAL : EXC_NONE;
                        if (d_ill || d_mfhi || d_mflo) begin
                            state <= S_WB;
                        end else begin
                            ctrl_q <= d_ctrl;
                            srca_q <= d_shamt ?
                                {27'd0, bus.req_shamt} :
                                bus.req_rs_data;
                            srcb_q <= bus.req_rt_data;
                            state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.alu_done) begin
                        res_q <= bus.alu_result;
                        if (trap_q && bus.alu_overflow)
                            exc_q <= EXC_OVF;
                        ctrl_q <= '0;
                        srca_q <= '0;
                        srcb_q <= '0;
                        state  <= S_WB;
                    end else if (cnt == CNT_LAST) begin
                        exc_q  <= EXC_TIMEOUT;
                        ctrl_q <= '0;
                        srca_q <= '0;
                        srcb_q <= '0;
                        state  <= S_WB;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WB: begin
                    cnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // MFHI/MFLO read the live hi/lo ports during WB.
    always_comb begin
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.exc_valid = 1'b0;
        bus.exc_code  = EXC_NONE;
        if (state == S_WB) begin
            if (exc_q != EXC_NONE) begin
                bus.exc_valid = 1'b1;
                bus.exc_code  = exc_q;
            end else if (wr_q && rd_q != 5'd0) begin
                bus.wb_valid = 1'b1;
                bus.wb_addr  = rd_q;
                bus.wb_data  = mfhi_q ? bus.alu_hi :
                               mflo_q ? bus.alu_lo : res_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU and a
// scoreboard of expected writeback/exception strobes.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          kind;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int en_count = 0;
    logic [3:0]  last_ctrl = '0;
    logic [31:0] last_a = '0;
    bit hang = 1'b0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] ma, mb, mr;
    logic [32:0] ms;
    logic [63:0] mp;
    logic        mo;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: answers one cycle after alu_en unless hung.
    always @(posedge clk) begin
        bus.alu_done <= 1'b0;
        if (bus.alu_en) begin
            en_count  <= en_count + 1;
            last_ctrl <= bus.alu_control;
            last_a    <= bus.alu_srcA;
            ma = bus.alu_srcA;
            mb = bus.alu_srcB;
            mr = '0;
            mo = 1'b0;
            case (bus.alu_control)
                ALU_ADD: begin
                    ms = {1'b0, ma} + {1'b0, mb};
                    mr = ms[31:0];
                    mo = ms[32];
                end
                ALU_SUB: begin
                    mr = ma - mb;
                    mo = (ma < mb);
                end
                ALU_AND: mr = ma & mb;
                ALU_OR:  mr = ma | mb;
                ALU_NOR: mr = ~(ma | mb);
                ALU_SLT: mr = ($signed(ma) < $signed(mb)) ? 32'd1 : 32'd0;
                ALU_SLL: mr = mb << ma[4:0];
                ALU_SRL: mr = mb >> ma[4:0];
                ALU_MULT: begin
                    mp = {32'd0, ma} * {32'd0, mb};
                    m_hi = mp[63:32];
                    m_lo = mp[31:0];
                end
                ALU_DIV: begin
                    mo = (mb == 32'd0);
                    if (mb != 32'd0) begin
                        m_lo = ma / mb;
                        m_hi = ma % mb;
                    end
                end
                default: mr = '0;
            endcase
            bus.alu_result   <= mr;
            bus.alu_overflow <= mo;
            bus.alu_hi       <= m_hi;
            bus.alu_lo       <= m_lo;
            if (!hang) bus.alu_done <= 1'b1;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (rst_n && (bus.wb_valid || bus.exc_valid)) begin
            checks++;
            if (bus.wb_valid && bus.exc_valid) begin
                errors++;
                $display("FAIL both_strobes wb=1 exc=1 required one");
            end else if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe wb=%0b exc=%0b code=%0d cyc=%0d required none",
                         bus.wb_valid, bus.exc_valid, bus.exc_code, cyc);
            end else begin
                mon_e = sbq.pop_front();
                if ((bus.wb_valid ? 1 : 2) != mon_e.kind ||
                    cyc != mon_e.cyc ||
                    (bus.wb_valid && (bus.wb_addr !== mon_e.addr ||
                                      bus.wb_data !== mon_e.data)) ||
                    (bus.exc_valid && bus.exc_code !== mon_e.code)) begin
                    errors++;
                    $display("FAIL strobe got wb=%0b addr=%0d data=%h exc=%0b code=%0d cyc=%0d required kind=%0d addr=%0d data=%h code=%0d cyc=%0d",
                             bus.wb_valid, bus.wb_addr, bus.wb_data,
                             bus.exc_valid, bus.exc_code, cyc,
                             mon_e.kind, mon_e.addr, mon_e.data,
                             mon_e.code, mon_e.cyc);
                end
            end
        end
    end

    // kind: 0 no strobe, 1 writeback, 2 exception. Call at a negedge.
    task automatic issue(input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] rs,
                         input logic [31:0] rtv, input logic [4:0] rd,
                         input int kind, input logic [31:0] data,
                         input logic [1:0] code, input int lat,
                         output int hs);
        exp_t e;
        int n;
        bus.req_opcode  = op;
        bus.req_funct   = fn;
        bus.req_shamt   = sh;
        bus.req_rs_data = rs;
        bus.req_rt_data = rtv;
        bus.req_rd      = rd;
        bus.req_valid   = 1'b1;
        hs = -1;
        n = 0;
        while (hs < 0 && n < 20) begin
            if (bus.req_ready) begin
                hs = cyc;
                if (kind != 0) begin
                    e.kind = kind;
                    e.addr = rd;
                    e.data = data;
                    e.code = code;
                    e.cyc  = cyc + lat;
                    sbq.push_back(e);
                end
            end
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (hs < 0) begin
            errors++;
            $display("FAIL handshake_timeout funct=%h got no ready required ready", fn);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_drain pending=%0d required 0", name, sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.alu_en !== 1'b0 ||
            bus.wb_valid !== 1'b0 || bus.exc_valid !== 1'b0 ||
            bus.alu_control !== 4'd0 || bus.alu_srcA !== 32'd0 ||
            bus.wb_data !== 32'd0 || bus.exc_code !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs ready=%b en=%b wb=%b exc=%b ctrl=%h required 1 0 0 0 0",
                     bus.req_ready, bus.alu_en, bus.wb_valid,
                     bus.exc_valid, bus.alu_control);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b required 1", bus.req_ready);
        end
    endtask

    task automatic test_add();
        int hs;
        int en0 = en_count;
        issue(6'h00, F_ADD, 5'd0, 32'd5, 32'd7, 5'd3, 1, 32'd12, 2'd0, 3, hs);
        drain("add");
        checks++;
        if (en_count - en0 != 1 || last_ctrl !== ALU_ADD) begin
            errors++;
            $display("FAIL add_issue en=%0d ctrl=%0d required 1 0",
                     en_count - en0, last_ctrl);
        end
    endtask

    task automatic test_overflow();
        int hs;
        issue(6'h00, F_ADD, 5'd0, 32'hFFFFFFFF, 32'd1, 5'd4,
              2, 32'd0, EXC_OVF, 3, hs);
        drain("add_ovf");
        issue(6'h00, F_ADDU, 5'd0, 32'hFFFFFFFF, 32'd1, 5'd4,
              1, 32'd0, 2'd0, 3, hs);
        drain("addu");
        issue(6'h00, F_SUBU, 5'd0, 32'd3, 32'd10, 5'd5,
              1, 32'hFFFFFFF9, 2'd0, 3, hs);
        drain("subu");
        issue(6'h00, F_SUB, 5'd0, 32'd3, 32'd10, 5'd5,
              2, 32'd0, EXC_OVF, 3, hs);
        drain("sub_ovf");
    endtask

    task automatic test_shift();
        int hs;
        int en0;
        issue(6'h00, F_SLL, 5'd4, 32'hDEAD0000, 32'd1, 5'd2,
              1, 32'd16, 2'd0, 3, hs);
        drain("sll");
        checks++;
        if (last_a !== 32'd4 || last_ctrl !== ALU_SLL) begin
            errors++;
            $display("FAIL sll_srcA got a=%h ctrl=%0d required 4 6",
                     last_a, last_ctrl);
        end
        en0 = en_count;
        issue(6'h00, F_SLL, 5'd4, 32'd0, 32'd1, 5'd0,
              0, 32'd0, 2'd0, 0, hs);
        repeat (6) @(negedge clk);
        checks++;
        if (en_count - en0 != 1) begin
            errors++;
            $display("FAIL sll_rd0_issue en=%0d required 1", en_count - en0);
        end
    endtask

    task automatic test_muldiv();
        int hs;
        issue(6'h00, F_MULT, 5'd0, 32'd3, 32'd4, 5'd9, 0, 32'd0, 2'd0, 0, hs);
        issue(6'h00, F_MFLO, 5'd0, 32'd0, 32'd0, 5'd8, 1, 32'd12, 2'd0, 1, hs);
        drain("mflo");
        issue(6'h00, F_MFHI, 5'd0, 32'd0, 32'd0, 5'd7, 1, 32'd0, 2'd0, 1, hs);
        drain("mfhi");
        issue(6'h00, F_DIV, 5'd0, 32'd5, 32'd0, 5'd6,
              2, 32'd0, EXC_OVF, 3, hs);
        drain("div0");
        issue(6'h00, F_MFLO, 5'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0, 2'd0, 0, hs);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_illegal();
        int hs;
        int en0 = en_count;
        issue(6'h00, 6'h3F, 5'd0, 32'd1, 32'd1, 5'd3,
              2, 32'd0, EXC_ILLEGAL, 1, hs);
        issue(6'h08, F_ADD, 5'd0, 32'd1, 32'd1, 5'd3,
              2, 32'd0, EXC_ILLEGAL, 1, hs);
        drain("illegal");
        checks++;
        if (en_count != en0) begin
            errors++;
            $display("FAIL illegal_no_en got %0d required 0", en_count - en0);
        end
    endtask

    task automatic test_back_to_back();
        int hs[6];
        issue(6'h00, F_SUB, 5'd0, 32'd10, 32'd3, 5'd6, 1, 32'd7, 2'd0, 3, hs[0]);
        issue(6'h00, F_AND, 5'd0, 32'hF0, 32'h3C, 5'd7, 1, 32'h30, 2'd0, 3, hs[1]);
        issue(6'h00, F_OR, 5'd0, 32'hF0, 32'h3C, 5'd8, 1, 32'hFC, 2'd0, 3, hs[2]);
        issue(6'h00, F_NOR, 5'd0, 32'd0, 32'd0, 5'd9, 1, 32'hFFFFFFFF, 2'd0, 3, hs[3]);
        issue(6'h00, F_SLT, 5'd0, 32'hFFFFFFFF, 32'd1, 5'd10, 1, 32'd1, 2'd0, 3, hs[4]);
        issue(6'h00, F_SRL, 5'd8, 32'd0, 32'h1200, 5'd11, 1, 32'h12, 2'd0, 3, hs[5]);
        drain("b2b");
        for (int i = 1; i < 6; i++) begin
            checks++;
            if (hs[i] - hs[i-1] != 4) begin
                errors++;
                $display("FAIL b2b_spacing idx=%0d got %0d required 4",
                         i, hs[i] - hs[i-1]);
            end
        end
    endtask

    task automatic test_timeout_reset();
        int hs;
        hang = 1'b1;
        issue(6'h00, F_ADD, 5'd0, 32'd1, 32'd2, 5'd3,
              2, 32'd0, EXC_TIMEOUT, 10, hs);
        drain("timeout");
        issue(6'h00, F_ADD, 5'd0, 32'd1, 32'd2, 5'd3, 0, 32'd0, 2'd0, 0, hs);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.alu_en !== 1'b0 ||
            bus.wb_valid !== 1'b0 || bus.exc_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset ready=%b en=%b wb=%b exc=%b required 1 0 0 0",
                     bus.req_ready, bus.alu_en, bus.wb_valid, bus.exc_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hang = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b required 1", bus.req_ready);
        end
        issue(6'h00, F_ADD, 5'd0, 32'd2, 32'd2, 5'd1, 1, 32'd4, 2'd0, 3, hs);
        drain("recover");
    endtask

    initial begin
        bus.req_valid   = 1'b0;
        bus.req_opcode  = '0;
        bus.req_funct   = '0;
        bus.req_shamt   = '0;
        bus.req_rs_data = '0;
        bus.req_rt_data = '0;
        bus.req_rd      = '0;
        test_reset();
        test_add();
        test_overflow();
        test_shift();
        test_muldiv();
        test_illegal();
        test_back_to_back();
        test_timeout_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
